vga_sync_receiver: RTL and testbench

Receive-side counterpart of the on-board VGA timing generator: consumes the 640x480@60 sync, blank and 8-bit RGB stream on the 25 MHz pixel clock, measures line/frame timing, locks to it, and re-emits pixels tagged with recovered X/Y coordinates. Used for loopback self-test of the display path and as the front end of the frame-capture path.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_rx_edge.sv | 38 +++
 rtl/vga_sync_receiver.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: nominal 640x480@60 timing shared with the transmitter, receiver
// lock-FSM state encoding and counter widths.
package vga_timing_pkg;

  localparam int NOM_H_TOTAL = 800;
  localparam int NOM_V_TOTAL = 525;
  localparam int NOM_H_ACT   = 640;
  localparam int NOM_V_ACT   = 480;

  localparam int HCNT_W = 11;
  localparam int LCNT_W = 10;
  localparam int PIX_W  = 10;

  localparam logic [HCNT_W-1:0] HCNT_MAX = 11'd2047;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/vga_rx_edge.sv
// vga_rx_edge: input register for HS/VS/BLANK_N plus falling-edge pulses of the
// registered syncs (pulse is high the cycle after the low level is captured).
module vga_rx_edge
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hs,
  input  logic vs,
  input  logic blank_n,
  output logic blank_q,
  output logic hs_fall,
  output logic vs_fall
);

  logic hs_q, vs_q, hs_d, vs_d;

  // capture stage and one-cycle delayed copies of the syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      blank_q <= blank_n;
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: measures and locks to a VGA sync/blank/RGB stream, re-emits pixels
// tagged with recovered X/Y. Define VGA_RX_CHECKSUM_EN to enable the frame_sum checksum.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = NOM_H_TOTAL,
  parameter int V_TOTAL     = NOM_V_TOTAL,
  parameter int H_ACT       = NOM_H_ACT,
  parameter int V_ACT       = NOM_V_ACT,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLK_25,
  input  logic        RST,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        clr_err,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_act,
  output logic [7:0]  err_count,
  output logic [15:0] frame_sum
);

  logic              blank_q, hs_fall, vs_fall;
  logic [7:0]        r_q, g_q, b_q;
  logic [HCNT_W-1:0] hcnt;
  logic [LCNT_W-1:0] lcnt, lcnt_line;
  logic [PIX_W-1:0]  xcnt, ycnt, x_cur, y_cur, act_lines;
  logic [3:0]        good, good_next;
  rx_state_t         state, state_next;
  logic              frame_bad, capture, checking, line_has_act;
  logic              hlen_bad, act_bad, vlen_bad, timeout, line_err, frame_good;
  logic              ev_hlen, ev_act, ev_vlen;
  logic [1:0]        n_ev;

  vga_rx_edge u_edge (
    .clk     (CLK_25),
    .rst     (RST),
    .hs      (VGA_HS),
    .vs      (VGA_VS),
    .blank_n (VGA_BLANK_N),
    .blank_q (blank_q),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall)
  );

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
    end else begin
      r_q <= VGA_R;
      g_q <= VGA_G;
      b_q <= VGA_B;
    end
  end

  // A line closing on the same cycle as VS fall is counted before the frame closes.
  always_comb begin
    line_has_act = (xcnt != 10'd0);
    lcnt_line    = hs_fall ? lcnt + 10'd1 : lcnt;
    act_lines    = (hs_fall && line_has_act) ? ycnt + 10'd1 : ycnt;
    x_cur        = hs_fall ? 10'd0 : xcnt;
    y_cur        = vs_fall ? 10'd0 : act_lines;
    checking     = (state != ST_SEARCH);
    capture      = blank_q && (state == ST_LOCKED);
    hlen_bad     = hs_fall && (hcnt != HCNT_W'(H_TOTAL));
    act_bad      = hs_fall && (state == ST_LOCKED) && line_has_act && (xcnt != PIX_W'(H_ACT));
    timeout      = !hs_fall && (hcnt == HCNT_MAX - 11'd1);
    vlen_bad     = vs_fall && ((lcnt_line != LCNT_W'(V_TOTAL)) || (act_lines != PIX_W'(V_ACT)));
    line_err     = hlen_bad || act_bad || timeout;
    frame_good   = !frame_bad && !line_err && !vlen_bad;
    // no reference timing exists while searching, so nothing is flagged there
    ev_hlen      = checking && (hlen_bad || timeout);
    ev_act       = act_bad;
    ev_vlen      = checking && vlen_bad;
    n_ev         = {1'b0, ev_hlen} + {1'b0, ev_act} + {1'b0, ev_vlen};
  end

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      hcnt   <= 11'd0;
      lcnt   <= 10'd0;
      xcnt   <= 10'd0;
      ycnt   <= 10'd0;
      h_meas <= 11'd0;
      v_meas <= 10'd0;
    end else begin
      if (hs_fall) begin
        hcnt   <= 11'd1;
        h_meas <= hcnt;
      end else if (hcnt != HCNT_MAX) begin
        hcnt <= hcnt + 11'd1;
      end
      lcnt <= vs_fall ? 10'd0 : lcnt_line;
      if (vs_fall) v_meas <= lcnt_line;
      xcnt <= x_cur + {9'd0, blank_q};
      ycnt <= y_cur;
    end
  end

  always_ff @(posedge CLK_25) begin
    if (RST || vs_fall) frame_bad <= 1'b0;
    else                frame_bad <= frame_bad | line_err;
  end

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      state <= ST_SEARCH;
      good  <= 4'd0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_next = ST_ALIGN;
          good_next  = 4'd0;
        end else begin
          state_next = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        if (timeout) begin
          state_next = ST_SEARCH;
          good_next  = 4'd0;
        end else if (vs_fall && frame_good) begin
          good_next = good + 4'd1;
          if (({1'b0, good} + 5'd1) >= 5'(LOCK_FRAMES)) state_next = ST_LOCKED;
          else                                          state_next = ST_ALIGN;
        end else if (vs_fall) begin
          good_next = 4'd0;
        end else begin
          state_next = ST_ALIGN;
        end
      end
      ST_LOCKED: begin
        if (line_err || vlen_bad) state_next = ST_SEARCH;
        else                      state_next = ST_LOCKED;
      end
      default: begin
        state_next = ST_SEARCH;
        good_next  = 4'd0;
      end
    endcase
  end

  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // an error arriving with clr_err survives the clear
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      err_hlen  <= 1'b0;
      err_vlen  <= 1'b0;
      err_act   <= 1'b0;
      err_count <= 8'd0;
    end else if (clr_err) begin
      err_hlen  <= ev_hlen;
      err_vlen  <= ev_vlen;
      err_act   <= ev_act;
      err_count <= {6'd0, n_ev};
    end else begin
      err_hlen  <= err_hlen | ev_hlen;
      err_vlen  <= err_vlen | ev_vlen;
      err_act   <= err_act | ev_act;
      err_count <= sat_add8(err_count, n_ev);
    end
  end

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
    end else begin
      pix_valid   <= capture;
      line_start  <= capture && (x_cur == 10'd0);
      frame_start <= capture && (x_cur == 10'd0) && (y_cur == 10'd0);
      if (capture) begin
        pix_x <= x_cur;
        pix_y <= y_cur;
        pix_r <= r_q;
        pix_g <= g_q;
        pix_b <= b_q;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc;
  logic        full_frame;

  // full_frame marks a frame that started while locked and has stayed locked since
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      acc        <= 16'd0;
      full_frame <= 1'b0;
      frame_sum  <= 16'd0;
    end else if (vs_fall) begin
      acc        <= 16'd0;
      full_frame <= (state_next == ST_LOCKED);
      if (full_frame && (state == ST_LOCKED) && (state_next == ST_LOCKED)) frame_sum <= acc;
    end else begin
      if (capture) acc <= acc + {8'd0, r_q} + {8'd0, g_q} + {8'd0, b_q};
      if (state_next != ST_LOCKED) full_frame <= 1'b0;
    end
  end
`else
  assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed frames on scaled-down timing (20x12 totals, 8x6 active)
// covering lock, capture, line/frame/timeout errors, clr_err priority and reset.
module tb_vga_sync_receiver;

  localparam int HT = 20, VT = 12, HA = 8, VA = 6, LF = 2;
  localparam int HS_BEG = 12, HS_END = 16, VS_LINE = 8;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, hs, vs, blank_n, clr_err;
  logic [7:0]  r, g, b;
  logic        pix_valid, line_start, frame_start, locked;
  logic        err_hlen, err_vlen, err_act;
  logic [9:0]  pix_x, pix_y, v_meas;
  logic [7:0]  pix_r, pix_g, pix_b, err_count;
  logic [10:0] h_meas;
  logic [15:0] frame_sum;

  int n_checks = 0, n_errors = 0;
  bit mon_en;
  int pv_cnt, ls_cnt, fs_cnt, mon_bad, ex, ey;

  vga_sync_receiver #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACT(HA), .V_ACT(VA), .LOCK_FRAMES(LF)) dut (
    .CLK_25(clk), .RST(rst), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .clr_err(clr_err),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_meas(h_meas), .v_meas(v_meas),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .err_act(err_act),
    .err_count(err_count), .frame_sum(frame_sum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    pv_cnt = 0; ls_cnt = 0; fs_cnt = 0; mon_bad = 0; ex = 0; ey = 0;
  endtask

  // one frame; short_line is one clock short, clr_err pulses where line clr_line's HS fall is seen
  task automatic drive_frame(input int nlines, input int short_line, input int clr_line, input bit flat);
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        hs      = !(h >= HS_BEG && h < HS_END);
        vs      = !((l == VS_LINE && h >= HS_BEG) || l == VS_LINE + 1 || (l == VS_LINE + 2 && h < HS_BEG));
        blank_n = (h < HA) && (l < VA);
        r       = flat ? 8'd1 : 8'(h);
        g       = flat ? 8'd1 : 8'(l);
        b       = 8'd1;
        clr_err = (l == clr_line) && (h == HS_BEG + 1);
        step();
        if (mon_en) begin
          if (pix_valid) begin
            pv_cnt++;
            if (pix_x !== 10'(ex) || pix_y !== 10'(ey) || pix_r !== 8'(ex) || pix_g !== 8'(ey) || pix_b !== 8'd1)
              mon_bad++;
            ex++;
            if (ex == HA) begin ex = 0; ey++; end
          end
          if (line_start) ls_cnt++;
          if (frame_start) fs_cnt++;
        end
      end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; clr_err = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0; mon_en = 1'b0;
    mon_clear();
    repeat (3) step();
    check("rst_locked", locked, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_h_meas", h_meas, 0);
    check("rst_v_meas", v_meas, 0);
    check("rst_frame_sum", frame_sum, 0);
    rst = 1'b0;

    // frames 0..2: SEARCH -> ALIGN -> good 1 -> good 2 = locked
    mon_en = 1'b1;
    repeat (3) drive_frame(VT, -1, -1, 1'b0);
    check("prelock_pix_count", pv_cnt, 0);
    check("locked_after_2_good", locked, 1);
    check("h_meas", h_meas, HT);
    check("v_meas", v_meas, VT);

    mon_clear();
    drive_frame(VT, -1, -1, 1'b0);
    mon_en = 1'b0;
    check("frame_pix_count", pv_cnt, HA * VA);
    check("coord_colour_bad", mon_bad, 0);
    check("line_starts", ls_cnt, VA);
    check("frame_starts", fs_cnt, 1);

    drive_frame(VT, -1, -1, 1'b1);
`ifdef VGA_RX_CHECKSUM_EN
    check("frame_sum", frame_sum, HA * VA * 3);
`else
    check("frame_sum", frame_sum, 0);
`endif
    check("no_err_flags", {err_hlen, err_vlen, err_act}, 0);
    check("no_err_count", err_count, 0);

    // short line while locked
    drive_frame(VT, 2, -1, 1'b0);
    check("short_err_hlen", err_hlen, 1);
    check("short_err_count", err_count, 1);
    check("short_unlocked", locked, 0);
    check("short_err_vlen", err_vlen, 0);

    // 11-line frame with a lone clr_err; frame is judged at the following VS fall
    drive_frame(VT - 1, -1, 0, 1'b0);
    check("clr_flags", {err_hlen, err_vlen, err_act}, 0);
    check("clr_count", err_count, 0);
    drive_frame(VT, -1, -1, 1'b0);
    check("vlen_err_vlen", err_vlen, 1);
    check("vlen_v_meas", v_meas, VT - 1);
    check("vlen_err_count", err_count, 1);
    drive_frame(VT, -1, -1, 1'b0);
    check("good_reset_unlocked", locked, 0);
    drive_frame(VT, -1, -1, 1'b0);
    check("relock", locked, 1);

    // new error in the same cycle as clr_err
    drive_frame(VT, 2, 3, 1'b0);
    check("clr_same_err_hlen", err_hlen, 1);
    check("clr_same_err_vlen", err_vlen, 0);
    check("clr_same_count", err_count, 1);
    check("clr_same_unlocked", locked, 0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, 0, 1'b0);
    check("relock2", locked, 1);
    check("relock2_count", err_count, 0);

    // HS stuck high: hcnt saturates
    hs = 1'b1; vs = 1'b1; blank_n = 1'b0;
    repeat (2100) step();
    check("timeout_err_hlen", err_hlen, 1);
    check("timeout_count", err_count, 1);
    check("timeout_search", locked, 0);

    repeat (3) drive_frame(VT, -1, -1, 1'b0);
    check("relock_after_timeout", locked, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_locked", locked, 0);
    check("midrst_err_hlen", err_hlen, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_h_meas", h_meas, 0);
    check("midrst_v_meas", v_meas, 0);
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, -1, -1, 1'b0);
    check("midrst_not_yet_locked", locked, 0);
    drive_frame(VT, -1, -1, 1'b0);
    check("midrst_relock", locked, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
